minterm_sweep_checker: RTL and testbench

MINTERM_SWEEP_CHECKER -- requirements
Module: minterm_sweep_checker

---
 rtl/sweep_pkg.sv | 18 +
 rtl/minterm_eval.sv | 18 +
 rtl/minterm_sweep_checker.sv | 170 +++++++++++++++++
 tb/tb_minterm_sweep_checker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and constants for the minterm sweep checker and its helpers.
package sweep_pkg;

    // Sweep controller states: idle, hold a vector, sample the response, report.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweepState_t;

    // Default function F = m(0,1,8,9,10,11,12,14,15) for a 4-input function.
    localparam logic [15:0] DEFAULT_MASK = 16'hDF03;

    // Width of the settle counter; covers SETTLE values 1..15.
    localparam int SETTLE_W = 4;

endpackage

// File: rtl/minterm_eval.sv
// Combinational truth-table lookup: returns F(vec) from a minterm mask.
// Usable standalone as a golden reference model for the function.
module minterm_eval
    import sweep_pkg::*;
#(
    parameter int                   N_IN         = 4,
    parameter logic [2**N_IN-1:0]   MINTERM_MASK = DEFAULT_MASK
) (
    input  logic [N_IN-1:0] i_vec,
    output logic            o_exp
);

    // Bit i of the mask is the function value for input vector i.
    always_comb begin
        o_exp = MINTERM_MASK[i_vec];
    end

endmodule

// File: rtl/minterm_sweep_checker.sv
// Exhaustive sweep checker: drives every input vector 0..2**N_IN-1 to an
// external device, waits SETTLE cycles, samples its response and compares
// against the expected function value, collecting error statistics.
module minterm_sweep_checker
    import sweep_pkg::*;
#(
    parameter int                   N_IN         = 4,
    parameter logic [2**N_IN-1:0]   MINTERM_MASK = DEFAULT_MASK,
    parameter int                   SETTLE       = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] vec_out,
    output logic            exp_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   ones_count,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_idx,
    output logic            first_err_valid
);

    localparam logic [N_IN-1:0]     LAST_VEC    = '1;
    localparam logic [N_IN-1:0]     VEC_ONE     = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]       CNT_ONE     = {{N_IN{1'b0}}, 1'b1};
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = {{(SETTLE_W-1){1'b0}}, 1'b1};

    sweepState_t          r_state;
    sweepState_t          w_nextState;
    logic [SETTLE_W-1:0]  r_settleCnt;
    logic [N_IN-1:0]      r_vec;
    logic [N_IN:0]        r_onesCnt;
    logic [N_IN:0]        r_errCnt;
    logic [N_IN-1:0]      r_firstErrIdx;
    logic                 r_firstErrValid;
    logic                 r_pass;
    logic                 r_done;

    logic                 w_exp;
    logic                 w_accept;
    logic                 w_settleDone;
    logic                 w_lastVec;
    logic                 w_mismatch;

    minterm_eval #(
        .N_IN         (N_IN),
        .MINTERM_MASK (MINTERM_MASK)
    ) u_eval (
        .i_vec (r_vec),
        .o_exp (w_exp)
    );

    // Decode the conditions that steer the controller and datapath.
    always_comb begin
        w_accept     = (r_state == IDLE) && start;
        w_settleDone = (r_settleCnt == SETTLE_LAST);
        w_lastVec    = (r_vec == LAST_VEC);
        w_mismatch   = (dut_out != w_exp);
    end

    // State register; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; start is only honoured while idle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = DRIVE;
                end
            end
            DRIVE: begin
                if (w_settleDone) begin
                    w_nextState = SAMPLE;
                end
            end
            SAMPLE: begin
                if (w_lastVec) begin
                    w_nextState = DONE;
                end else begin
                    w_nextState = DRIVE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Count the cycles a vector has been held; restarts for every vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settleCnt <= '0;
        end else if (r_state == DRIVE && !w_settleDone) begin
            r_settleCnt <= r_settleCnt + SETTLE_ONE;
        end else begin
            r_settleCnt <= '0;
        end
    end

    // Vector stepping, response scoring and end-of-sweep verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec           <= '0;
            r_onesCnt       <= '0;
            r_errCnt        <= '0;
            r_firstErrIdx   <= '0;
            r_firstErrValid <= 1'b0;
            r_pass          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_vec           <= '0;
                r_onesCnt       <= '0;
                r_errCnt        <= '0;
                r_firstErrIdx   <= '0;
                r_firstErrValid <= 1'b0;
                r_pass          <= 1'b0;
            end
            if (r_state == SAMPLE) begin
                if (dut_out) begin
                    r_onesCnt <= r_onesCnt + CNT_ONE;
                end
                if (w_mismatch) begin
                    r_errCnt <= r_errCnt + CNT_ONE;
                    if (!r_firstErrValid) begin
                        r_firstErrIdx   <= r_vec;
                        r_firstErrValid <= 1'b1;
                    end
                end
                if (!w_lastVec) begin
                    r_vec <= r_vec + VEC_ONE;
                end
            end
            if (r_state == DONE) begin
                r_done <= 1'b1;
                r_pass <= (r_errCnt == '0);
            end
        end
    end

    // Drive the ports from the registered state.
    always_comb begin
        vec_out         = r_vec;
        exp_out         = w_exp;
        busy            = (r_state != IDLE);
        done            = r_done;
        pass            = r_pass;
        ones_count      = r_onesCnt;
        err_count       = r_errCnt;
        first_err_idx   = r_firstErrIdx;
        first_err_valid = r_firstErrValid;
    end

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Directed self-checking bench for the minterm sweep checker.
module tb_minterm_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       startA;
    logic       startB;
    logic [1:0] modeA;

    logic       dutOutA;
    logic [3:0] vecA;
    logic       expA, busyA, doneA, passA, validA;
    logic [4:0] onesA, errA;
    logic [3:0] idxA;

    logic       dutOutB;
    logic [2:0] vecB;
    logic       expB, busyB, doneB, passB, validB;
    logic [3:0] onesB, errB;
    logic [2:0] idxB;

    logic [15:0] maskA = 16'hDF03;
    logic [7:0]  maskB = 8'hA5;

    int checks   = 0;
    int failures = 0;
    int doneCyc;
    int doneNum;

    minterm_sweep_checker uA (
        .clk             (clk),
        .rst             (rst),
        .start           (startA),
        .dut_out         (dutOutA),
        .vec_out         (vecA),
        .exp_out         (expA),
        .busy            (busyA),
        .done            (doneA),
        .pass            (passA),
        .ones_count      (onesA),
        .err_count       (errA),
        .first_err_idx   (idxA),
        .first_err_valid (validA)
    );

    minterm_sweep_checker #(
        .N_IN         (3),
        .MINTERM_MASK (8'hA5),
        .SETTLE       (2)
    ) uB (
        .clk             (clk),
        .rst             (rst),
        .start           (startB),
        .dut_out         (dutOutB),
        .vec_out         (vecB),
        .exp_out         (expB),
        .busy            (busyB),
        .done            (doneB),
        .pass            (passB),
        .ones_count      (onesB),
        .err_count       (errB),
        .first_err_idx   (idxB),
        .first_err_valid (validB)
    );

    always #5 clk = ~clk;

    // Model of the external device: golden, single fault at vector 10, or stuck-at-0.
    always_comb begin
        case (modeA)
            2'd0:    dutOutA = maskA[vecA];
            2'd1:    dutOutA = maskA[vecA] ^ (vecA == 4'd10);
            default: dutOutA = 1'b0;
        endcase
        dutOutB = maskB[vecB];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Run instance A for maxc edges after an accepted start, with optional extra
    // start pulses and a reset pulse; report the first done edge and pulse count.
    task automatic applyStimulus(input int p1, input int p2, input int rc, input int maxc,
                                 input bit chk, output int dc, output int dn);
        dc = 0;
        dn = 0;
        for (int k = 1; k <= maxc; k++) begin
            startA = (k == p1) || (k == p2);
            rst    = (k == rc);
            tick();
            startA = 1'b0;
            rst    = 1'b0;
            if (doneA) begin
                dn++;
                if (dc == 0) dc = k;
            end
            if (chk && k == 1) checkOutput("busy_in_sweep", busyA, 1);
            if (chk && k == 2) checkOutput("vec_after_first_sample", vecA, 1);
            if (chk && k == 2) checkOutput("exp_at_vec1", expA, 1);
            if (chk && k == 6) checkOutput("exp_at_vec3", expA, 0);
            if (chk && k == 32) checkOutput("busy_in_done_state", busyA, 1);
            if (k == rc) begin
                checkOutput("rst_vec", vecA, 0);
                checkOutput("rst_busy", busyA, 0);
                checkOutput("rst_done", doneA, 0);
                checkOutput("rst_pass", passA, 0);
                checkOutput("rst_ones", onesA, 0);
                checkOutput("rst_err", errA, 0);
                checkOutput("rst_idx", idxA, 0);
                checkOutput("rst_valid", validA, 0);
            end
        end
    endtask

    task automatic acceptStart();
        startA = 1'b1;
        tick();
        startA = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        startA = 1'b0;
        startB = 1'b0;
        modeA  = 2'd0;
        tick();
        tick();

        checkOutput("reset_vec", vecA, 0);
        checkOutput("reset_exp", expA, 1);
        checkOutput("reset_busy", busyA, 0);
        checkOutput("reset_done", doneA, 0);
        checkOutput("reset_pass", passA, 0);
        checkOutput("reset_ones", onesA, 0);
        checkOutput("reset_err", errA, 0);
        checkOutput("reset_valid", validA, 0);
        checkOutput("reset_busyB", busyB, 0);
        rst = 1'b0;
        tick();

        $display("[TB] golden sweep");
        modeA = 2'd0;
        acceptStart();
        applyStimulus(0, 0, 0, 45, 1'b1, doneCyc, doneNum);
        checkOutput("golden_done_cycle", doneCyc, 33);
        checkOutput("golden_done_count", doneNum, 1);
        checkOutput("golden_pass", passA, 1);
        checkOutput("golden_err", errA, 0);
        checkOutput("golden_ones", onesA, 9);
        checkOutput("golden_valid", validA, 0);
        checkOutput("golden_final_vec", vecA, 15);
        checkOutput("golden_idle_busy", busyA, 0);

        $display("[TB] single fault at vector 10");
        modeA = 2'd1;
        acceptStart();
        applyStimulus(0, 0, 0, 40, 1'b0, doneCyc, doneNum);
        checkOutput("fault_done_cycle", doneCyc, 33);
        checkOutput("fault_err", errA, 1);
        checkOutput("fault_idx", idxA, 10);
        checkOutput("fault_valid", validA, 1);
        checkOutput("fault_pass", passA, 0);
        checkOutput("fault_ones", onesA, 8);

        $display("[TB] stuck-at-0 device");
        modeA = 2'd2;
        acceptStart();
        applyStimulus(0, 0, 0, 40, 1'b0, doneCyc, doneNum);
        checkOutput("stuck_err", errA, 9);
        checkOutput("stuck_idx", idxA, 0);
        checkOutput("stuck_valid", validA, 1);
        checkOutput("stuck_ones", onesA, 0);
        checkOutput("stuck_pass", passA, 0);

        $display("[TB] start while busy");
        modeA = 2'd0;
        acceptStart();
        applyStimulus(5, 33, 0, 45, 1'b0, doneCyc, doneNum);
        checkOutput("busy_start_done_cycle", doneCyc, 33);
        checkOutput("busy_start_done_count", doneNum, 1);
        checkOutput("busy_start_err", errA, 0);
        checkOutput("busy_start_ones", onesA, 9);
        checkOutput("busy_start_pass", passA, 1);
        checkOutput("busy_start_idle", busyA, 0);

        $display("[TB] reset mid-sweep");
        acceptStart();
        applyStimulus(0, 0, 12, 45, 1'b0, doneCyc, doneNum);
        checkOutput("abort_done_count", doneNum, 0);
        acceptStart();
        applyStimulus(0, 0, 0, 40, 1'b0, doneCyc, doneNum);
        checkOutput("restart_done_cycle", doneCyc, 33);
        checkOutput("restart_pass", passA, 1);
        checkOutput("restart_ones", onesA, 9);

        $display("[TB] reset and start together");
        rst    = 1'b1;
        startA = 1'b1;
        tick();
        rst    = 1'b0;
        startA = 1'b0;
        checkOutput("rst_start_busy", busyA, 0);
        checkOutput("rst_start_pass", passA, 0);
        tick();
        checkOutput("rst_start_still_idle", busyA, 0);

        $display("[TB] N_IN=3 SETTLE=2 instance");
        startB = 1'b1;
        tick();
        startB = 1'b0;
        doneCyc = 0;
        doneNum = 0;
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (doneB) begin
                doneNum++;
                if (doneCyc == 0) doneCyc = k;
            end
        end
        checkOutput("n3_done_cycle", doneCyc, 25);
        checkOutput("n3_done_count", doneNum, 1);
        checkOutput("n3_ones", onesB, 4);
        checkOutput("n3_err", errB, 0);
        checkOutput("n3_pass", passB, 1);
        checkOutput("n3_final_vec", vecB, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
